// File: rtl/cnt_seq_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : cnt_seq_checker_if
// Brief    : Counter inputs, control and status bundle for cnt_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
interface cnt_seq_checker_if #(
  parameter int ERR_W = 8
);
  logic             clr;
  logic             chk_en;
  logic [3:0]       cnt_s;
  logic [3:0]       cnt_a;
  logic             locked_s;
  logic             locked_a;
  logic             err_s;
  logic             err_a;
  logic [ERR_W-1:0] err_cnt_s;
  logic [ERR_W-1:0] err_cnt_a;
  logic             skew_err;
  logic             first_err_vld;
  logic             first_err_ch;
  logic [3:0]       first_err_val;

  modport master (
    output clr, chk_en, cnt_s, cnt_a,
    input  locked_s, locked_a, err_s, err_a, err_cnt_s, err_cnt_a,
           skew_err, first_err_vld, first_err_ch, first_err_val
  );

  modport slave (
    input  clr, chk_en, cnt_s, cnt_a,
    output locked_s, locked_a, err_s, err_a, err_cnt_s, err_cnt_a,
           skew_err, first_err_vld, first_err_ch, first_err_val
  );
endinterface
`default_nettype wire

// File: rtl/cnt_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : cnt_seq_checker
// Brief    : Lock/error monitor for the two period-8 register counters.
// Revision : 1.0 - initial release
// ============================================================================
module cnt_seq_checker #(
  parameter int LOCK_CNT = 4,
  parameter int ERR_W    = 8
) (
  input  logic             clock,
  input  logic             reset_,
  cnt_seq_checker_if.slave bus
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACQUIRE = 2'd1,
    ST_LOCKED  = 2'd2,
    ST_FAULT   = 2'd3
  } state_t;

  localparam logic [3:0]       c_LOCK_CNT = 4'(LOCK_CNT);
  localparam logic [ERR_W-1:0] c_ERR_MAX  = {ERR_W{1'b1}};
  localparam logic [ERR_W-1:0] c_ERR_ONE  = ERR_W'(1);

  // Index 0 is channel s, index 1 is channel a.
  logic [1:0] w_fault;
  logic [1:0] w_locked;

  genvar g;
  generate
    for (g = 0; g < 2; g++) begin : g_ch
      logic [3:0] w_cnt;
      logic [3:0] r_prev;
      logic [3:0] r_run;
      logic [3:0] w_run_nxt;
      state_t     r_state;
      state_t     w_state_nxt;
      logic       w_good;
      logic       w_fault_evt;

      assign w_cnt  = (g == 0) ? bus.cnt_s : bus.cnt_a;
      assign w_good = (w_cnt == {~r_prev[3], r_prev[2:0] + 3'd1});

      always_ff @(posedge clock or negedge reset_) begin
        if (!reset_) begin
          r_state <= ST_IDLE;
          r_run   <= 4'd0;
          r_prev  <= 4'd0;
        end else begin
          r_state <= w_state_nxt;
          r_run   <= w_run_nxt;
          r_prev  <= w_cnt;
        end
      end

      always_comb begin
        w_state_nxt = r_state;
        w_run_nxt   = r_run;
        w_fault_evt = 1'b0;
        if (!bus.chk_en) begin
          w_state_nxt = ST_IDLE;
          w_run_nxt   = 4'd0;
        end else begin
          case (r_state)
            ST_IDLE: begin
              w_state_nxt = ST_ACQUIRE;
              w_run_nxt   = 4'd0;
            end
            ST_ACQUIRE: begin
              if (w_good) begin
                w_run_nxt = r_run + 4'd1;
                if (w_run_nxt == c_LOCK_CNT) begin
                  w_state_nxt = ST_LOCKED;
                end
              end else begin
                w_run_nxt = 4'd0;
              end
            end
            ST_LOCKED: begin
              if (!w_good) begin
                w_state_nxt = ST_FAULT;
                w_fault_evt = 1'b1;
              end
            end
            ST_FAULT: begin
              w_state_nxt = ST_ACQUIRE;
              w_run_nxt   = 4'd0;
            end
            default: begin
              w_state_nxt = ST_IDLE;
              w_run_nxt   = 4'd0;
            end
          endcase
        end
      end

      assign w_fault[g]  = w_fault_evt;
      assign w_locked[g] = (r_state == ST_LOCKED);
    end
  endgenerate

  logic             r_err_s;
  logic             r_err_a;
  logic [ERR_W-1:0] r_err_cnt_s;
  logic [ERR_W-1:0] r_err_cnt_a;
  logic             r_skew_err;
  logic             r_first_vld;
  logic             r_first_ch;
  logic [3:0]       r_first_val;

  // clr wins over any same-edge set or increment.
  always_ff @(posedge clock or negedge reset_) begin
    if (!reset_) begin
      r_err_s     <= 1'b0;
      r_err_a     <= 1'b0;
      r_err_cnt_s <= '0;
      r_err_cnt_a <= '0;
      r_skew_err  <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_ch  <= 1'b0;
      r_first_val <= 4'd0;
    end else if (bus.clr) begin
      r_err_s     <= 1'b0;
      r_err_a     <= 1'b0;
      r_err_cnt_s <= '0;
      r_err_cnt_a <= '0;
      r_skew_err  <= 1'b0;
      r_first_vld <= 1'b0;
      r_first_ch  <= 1'b0;
      r_first_val <= 4'd0;
    end else begin
      if (w_fault[0]) begin
        r_err_s <= 1'b1;
        if (r_err_cnt_s != c_ERR_MAX) begin
          r_err_cnt_s <= r_err_cnt_s + c_ERR_ONE;
        end
      end
      if (w_fault[1]) begin
        r_err_a <= 1'b1;
        if (r_err_cnt_a != c_ERR_MAX) begin
          r_err_cnt_a <= r_err_cnt_a + c_ERR_ONE;
        end
      end
      if (w_locked[0] && w_locked[1] && (bus.cnt_s != bus.cnt_a)) begin
        r_skew_err <= 1'b1;
      end
      // Channel s takes precedence when both fault on the same edge.
      if (!r_first_vld && (w_fault != 2'b00)) begin
        r_first_vld <= 1'b1;
        r_first_ch  <= ~w_fault[0];
        r_first_val <= w_fault[0] ? bus.cnt_s : bus.cnt_a;
      end
    end
  end

  assign bus.locked_s      = w_locked[0];
  assign bus.locked_a      = w_locked[1];
  assign bus.err_s         = r_err_s;
  assign bus.err_a         = r_err_a;
  assign bus.err_cnt_s     = r_err_cnt_s;
  assign bus.err_cnt_a     = r_err_cnt_a;
  assign bus.skew_err      = r_skew_err;
  assign bus.first_err_vld = r_first_vld;
  assign bus.first_err_ch  = r_first_ch;
  assign bus.first_err_val = r_first_val;

endmodule
`default_nettype wire

// File: tb/tb_cnt_seq_checker.sv
`default_nettype none
// ============================================================================
// Module   : tb_cnt_seq_checker
// Brief    : Directed self-checking bench for cnt_seq_checker.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cnt_seq_checker;

  logic clock;
  logic reset_;
  int   checks = 0;
  int   errors = 0;

  logic [3:0] seq_s;
  logic [3:0] seq_a;

  cnt_seq_checker_if #(.ERR_W(8)) bus ();
  cnt_seq_checker_if #(.ERR_W(2)) bus2 ();

  cnt_seq_checker #(.LOCK_CNT(4), .ERR_W(8)) dut (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus)
  );

  cnt_seq_checker #(.LOCK_CNT(4), .ERR_W(2)) dut2 (
    .clock  (clock),
    .reset_ (reset_),
    .bus    (bus2)
  );

  // {locked_s, locked_a, err_s, err_a, skew_err, first_err_vld, first_err_ch}
  wire [6:0] flags = {bus.locked_s, bus.locked_a, bus.err_s, bus.err_a,
                      bus.skew_err, bus.first_err_vld, bus.first_err_ch};

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [3:0] nxt(input logic [3:0] x);
    return {~x[3], x[2:0] + 3'd1};
  endfunction

  // Present one sample (optionally corrupted in bit 0), clock it, settle.
  task automatic step(input bit bad_s, input bit bad_a);
    bus.cnt_s  = bad_s ? (seq_s ^ 4'b0001) : seq_s;
    bus.cnt_a  = bad_a ? (seq_a ^ 4'b0001) : seq_a;
    bus2.cnt_s = bus.cnt_s;
    bus2.cnt_a = bus.cnt_a;
    @(posedge clock);
    #1;
    seq_s = nxt(seq_s);
    seq_a = nxt(seq_a);
  endtask

  task automatic run_good(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0);
  endtask

  task automatic do_reset();
    reset_      = 1'b0;
    bus.clr     = 1'b0;
    bus.chk_en  = 1'b0;
    bus2.clr    = 1'b0;
    bus2.chk_en = 1'b0;
    seq_s       = 4'd0;
    seq_a       = 4'd0;
    bus.cnt_s   = 4'd0;
    bus.cnt_a   = 4'd0;
    bus2.cnt_s  = 4'd0;
    bus2.cnt_a  = 4'd0;
    @(posedge clock);
    #1;
    @(posedge clock);
    #3;
    reset_ = 1'b1;
  endtask

  task automatic test_reset();
    reset_      = 1'b0;
    bus.clr     = 1'b0;
    bus.chk_en  = 1'b0;
    bus2.clr    = 1'b0;
    bus2.chk_en = 1'b0;
    seq_s = 4'd0;  seq_a = 4'd0;
    bus.cnt_s = 4'd0;  bus.cnt_a = 4'd0;
    bus2.cnt_s = 4'd0; bus2.cnt_a = 4'd0;
    @(posedge clock);
    #1;
    checks++;
    if ({flags, bus.err_cnt_s, bus.err_cnt_a, bus.first_err_val} !== 27'd0) begin
      errors++;
      $display("FAIL reset_outputs got flags=%b cnt_s=%0d cnt_a=%0d val=%b want all 0",
               flags, bus.err_cnt_s, bus.err_cnt_a, bus.first_err_val);
    end
    #2;
    reset_     = 1'b1;
    bus.chk_en = 1'b1;
    run_good(4);
    checks++;
    if (flags !== 7'b0000000) begin
      errors++;
      $display("FAIL reset_prelock got flags=%b want 0000000", flags);
    end
    step(1'b0, 1'b0);
    checks++;
    if (flags !== 7'b1100000) begin
      errors++;
      $display("FAIL reset_lock got flags=%b want 1100000", flags);
    end
    checks++;
    if ({bus.err_cnt_s, bus.err_cnt_a} !== 16'd0) begin
      errors++;
      $display("FAIL reset_lock_cnt got s=%0d a=%0d want 0 0", bus.err_cnt_s, bus.err_cnt_a);
    end
  endtask

  task automatic test_single_fault();
    do_reset();
    bus.chk_en = 1'b1;
    run_good(5);
    for (int i = 0; i < 8 && seq_s != 4'b0100; i++) step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    checks++;
    if (flags !== 7'b0110110) begin
      errors++;
      $display("FAIL single_flags got %b want 0110110", flags);
    end
    checks++;
    if ({bus.err_cnt_s, bus.err_cnt_a} !== {8'd1, 8'd0}) begin
      errors++;
      $display("FAIL single_cnt got s=%0d a=%0d want 1 0", bus.err_cnt_s, bus.err_cnt_a);
    end
    checks++;
    if (bus.first_err_val !== 4'b0101) begin
      errors++;
      $display("FAIL single_val got %b want 0101", bus.first_err_val);
    end
    for (int i = 0; i < 4; i++) begin
      step(1'b0, 1'b0);
      checks++;
      if ({bus.locked_s, bus.locked_a} !== 2'b01) begin
        errors++;
        $display("FAIL single_relock_wait%0d got %b want 01", i, {bus.locked_s, bus.locked_a});
      end
    end
    step(1'b0, 1'b0);
    checks++;
    if ({bus.locked_s, bus.locked_a, bus.err_a, bus.err_cnt_s} !== {3'b110, 8'd1}) begin
      errors++;
      $display("FAIL single_relock got ls=%b la=%b ea=%b cnt_s=%0d want 1 1 0 1",
               bus.locked_s, bus.locked_a, bus.err_a, bus.err_cnt_s);
    end
  endtask

  task automatic test_dual_fault();
    logic [3:0] exp_val;
    do_reset();
    bus.chk_en = 1'b1;
    run_good(5);
    exp_val = seq_s ^ 4'b0001;
    step(1'b1, 1'b1);
    checks++;
    if (flags !== 7'b0011010) begin
      errors++;
      $display("FAIL dual_flags got %b want 0011010", flags);
    end
    checks++;
    if ({bus.err_cnt_s, bus.err_cnt_a} !== {8'd1, 8'd1}) begin
      errors++;
      $display("FAIL dual_cnt got s=%0d a=%0d want 1 1", bus.err_cnt_s, bus.err_cnt_a);
    end
    checks++;
    if (bus.first_err_val !== exp_val) begin
      errors++;
      $display("FAIL dual_val got %b want %b", bus.first_err_val, exp_val);
    end
  endtask

  task automatic test_clr_with_fault();
    do_reset();
    bus.chk_en = 1'b1;
    run_good(5);
    step(1'b1, 1'b0);
    run_good(5);
    checks++;
    if ({bus.locked_s, bus.err_cnt_s} !== {1'b1, 8'd1}) begin
      errors++;
      $display("FAIL clr_setup got ls=%b cnt_s=%0d want 1 1", bus.locked_s, bus.err_cnt_s);
    end
    bus.clr = 1'b1;
    step(1'b0, 1'b1);
    bus.clr = 1'b0;
    checks++;
    if (flags !== 7'b1000000) begin
      errors++;
      $display("FAIL clr_flags got %b want 1000000", flags);
    end
    checks++;
    if ({bus.err_cnt_s, bus.err_cnt_a, bus.first_err_val} !== 20'd0) begin
      errors++;
      $display("FAIL clr_stats got s=%0d a=%0d val=%b want 0 0 0000",
               bus.err_cnt_s, bus.err_cnt_a, bus.first_err_val);
    end
    step(1'b0, 1'b0);
    checks++;
    if (flags !== 7'b1000000) begin
      errors++;
      $display("FAIL clr_after got %b want 1000000", flags);
    end
    run_good(4);
    checks++;
    if ({bus.locked_a, bus.err_cnt_a} !== {1'b1, 8'd0}) begin
      errors++;
      $display("FAIL clr_relock got la=%b cnt_a=%0d want 1 0", bus.locked_a, bus.err_cnt_a);
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_cnt;
    do_reset();
    bus2.chk_en = 1'b1;
    run_good(5);
    checks++;
    if (bus2.locked_a !== 1'b1) begin
      errors++;
      $display("FAIL sat_lock got %b want 1", bus2.locked_a);
    end
    for (int k = 0; k < 5; k++) begin
      exp_cnt = (k >= 2) ? 2'd3 : 2'(k + 1);
      step(1'b0, 1'b1);
      checks++;
      if ({bus2.locked_a, bus2.err_cnt_a} !== {1'b0, exp_cnt}) begin
        errors++;
        $display("FAIL sat_fault%0d got la=%b cnt=%0d want 0 %0d",
                 k, bus2.locked_a, bus2.err_cnt_a, exp_cnt);
      end
      run_good(5);
      checks++;
      if (bus2.locked_a !== 1'b1) begin
        errors++;
        $display("FAIL sat_relock%0d got %b want 1", k, bus2.locked_a);
      end
    end
    checks++;
    if ({bus2.err_cnt_s, bus2.err_a, bus2.first_err_ch} !== 4'b0011) begin
      errors++;
      $display("FAIL sat_other got cnt_s=%0d ea=%b ch=%b want 0 1 1",
               bus2.err_cnt_s, bus2.err_a, bus2.first_err_ch);
    end
    checks++;
    if ({bus.locked_a, bus.err_cnt_a} !== 9'd0) begin
      errors++;
      $display("FAIL sat_disabled got la=%b cnt_a=%0d want 0 0", bus.locked_a, bus.err_cnt_a);
    end
  endtask

  task automatic test_reset_midlock();
    do_reset();
    bus.chk_en = 1'b1;
    run_good(5);
    step(1'b1, 1'b0);
    run_good(5);
    checks++;
    if (flags !== 7'b1110110) begin
      errors++;
      $display("FAIL midlock_setup got %b want 1110110", flags);
    end
    // Async-reset counter clears at once; the sync-reset one holds until the edge.
    #3;
    reset_    = 1'b0;
    bus.cnt_s = 4'd0;
    #1;
    checks++;
    if ({flags, bus.err_cnt_s, bus.err_cnt_a, bus.first_err_val} !== 27'd0) begin
      errors++;
      $display("FAIL midlock_async got flags=%b cnt_s=%0d cnt_a=%0d val=%b want all 0",
               flags, bus.err_cnt_s, bus.err_cnt_a, bus.first_err_val);
    end
    @(posedge clock);
    #1;
    bus.cnt_a = 4'd0;
    seq_s     = 4'd0;
    seq_a     = 4'd0;
    #2;
    reset_ = 1'b1;
    run_good(4);
    checks++;
    if (flags !== 7'b0000000) begin
      errors++;
      $display("FAIL midlock_prelock got %b want 0000000", flags);
    end
    step(1'b0, 1'b0);
    checks++;
    if ({flags, bus.err_cnt_s, bus.err_cnt_a} !== {7'b1100000, 16'd0}) begin
      errors++;
      $display("FAIL midlock_relock got flags=%b cnt_s=%0d cnt_a=%0d want 1100000 0 0",
               flags, bus.err_cnt_s, bus.err_cnt_a);
    end
  endtask

  initial begin
    test_reset();
    test_single_fault();
    test_dual_fault();
    test_clr_with_fault();
    test_saturation();
    test_reset_midlock();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
